addsub_sequencer: RTL and testbench

ADDSUB_SEQUENCER -- requirements
Module: addsub_sequencer

---
 rtl/addsub_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_addsub_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_sequencer.sv
// ---------------------------------------------------------------------------
// addsub_sequencer
//
// Control FSM for a small 8-bit add/subtract datapath. On an accepted start
// it loads operand A into the accumulator, then applies up to three further
// operands (B, C, D in that order), each added or subtracted as selected by
// `ops`. It then captures the accumulator into `result` and pulses `done`.
// Every LOAD/STEP state holds its datapath selects for STEP_CYCLES clocks.
//
// Parameters
//   STEP_CYCLES  clocks each select setting is held (1..15)
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous, active-low reset
//   start        request a new sequence (sampled only in IDLE)
//   terms[1:0]   number of operands after A (0..3), latched at start
//   ops[2:0]     per-operand op, bit0=B bit1=C bit2=D, 1=add 0=subtract
//   acc_in[7:0]  signed accumulator value fed back from the datapath
//   s0,s1,s2     datapath mux selects (registered)
//   addOrSub     adder control, 1=add 0=subtract (registered)
//   dpDone       datapath freeze, 1 = adder holds (registered)
//   busy         high in LOAD, STEP_* and DONE
//   done         single-cycle completion pulse
//   result[7:0]  signed final accumulator value
//
// Optional feature (macro ADDSUB_SEQ_ABORT_EN)
//   abort        input: abandon a running sequence (LOAD/STEP_* only)
//   aborted      output: single-cycle pulse after an abort is taken
// ---------------------------------------------------------------------------
module addsub_sequencer #(
  parameter int STEP_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        terms,
  input  logic [2:0]        ops,
  input  logic signed [7:0] acc_in,
`ifdef ADDSUB_SEQ_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic              s0,
  output logic              s1,
  output logic              s2,
  output logic              addOrSub,
  output logic              dpDone,
  output logic              busy,
  output logic              done,
  output logic signed [7:0] result
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STEP_B = 3'd2,
    STEP_C = 3'd3,
    STEP_D = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(STEP_CYCLES - 1);

  state_t      state_r;
  state_t      next_state_s;
  logic [3:0]  cnt_r;
  logic [1:0]  terms_r;
  logic [2:0]  ops_r;
  logic        last_cycle_s;
  logic        capture_s;
`ifdef ADDSUB_SEQ_ABORT_EN
  logic        abort_hit_s;
`endif

  // Next-state decode; the step chain is cut short by the latched term count.
  always_comb begin
    next_state_s = state_r;
    last_cycle_s = (cnt_r == CNT_LAST);
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = LOAD;
        end else begin
          next_state_s = IDLE;
        end
      end
      LOAD: begin
        if (last_cycle_s) begin
          next_state_s = (terms_r == 2'd0) ? DONE : STEP_B;
        end else begin
          next_state_s = LOAD;
        end
      end
      STEP_B: begin
        if (last_cycle_s) begin
          next_state_s = (terms_r >= 2'd2) ? STEP_C : DONE;
        end else begin
          next_state_s = STEP_B;
        end
      end
      STEP_C: begin
        if (last_cycle_s) begin
          next_state_s = (terms_r == 2'd3) ? STEP_D : DONE;
        end else begin
          next_state_s = STEP_C;
        end
      end
      STEP_D: begin
        if (last_cycle_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = STEP_D;
        end
      end
      DONE: begin
        // start is deliberately not looked at here; IDLE always follows.
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
`ifdef ADDSUB_SEQ_ABORT_EN
    // An abort only matters while the datapath is being sequenced.
    if (abort && (state_r != IDLE) && (state_r != DONE)) begin
      next_state_s = IDLE;
      abort_hit_s  = 1'b1;
    end else begin
      abort_hit_s  = 1'b0;
    end
`endif
    // Capture on the final cycle of the last LOAD/STEP state; an abort
    // redirects to IDLE and so never captures.
    capture_s = (next_state_s == DONE) && (state_r != DONE);
  end

  // FSM state, cycle counter, operand latches and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      terms_r  <= 2'd0;
      ops_r    <= 3'd0;
      result   <= 8'sd0;
      done     <= 1'b0;
      busy     <= 1'b0;
      s0       <= 1'b1;
      s1       <= 1'b0;
      s2       <= 1'b0;
      addOrSub <= 1'b1;
      dpDone   <= 1'b1;
`ifdef ADDSUB_SEQ_ABORT_EN
      aborted  <= 1'b0;
`endif
    end else begin
      state_r <= next_state_s;

      // Counter restarts on every state entry and idles at zero.
      if ((next_state_s != state_r) || (state_r == IDLE) || (state_r == DONE)) begin
        cnt_r <= 4'd0;
      end else begin
        cnt_r <= cnt_r + 4'd1;
      end

      if ((state_r == IDLE) && start) begin
        terms_r <= terms;
        ops_r   <= ops;
      end else begin
        terms_r <= terms_r;
        ops_r   <= ops_r;
      end

      if (capture_s) begin
        result <= acc_in;
      end else begin
        result <= result;
      end

      done <= (next_state_s == DONE);
      busy <= (next_state_s != IDLE);
`ifdef ADDSUB_SEQ_ABORT_EN
      aborted <= abort_hit_s;
`endif

      // Outputs are decoded from the state being entered, so they switch
      // exactly at entry and stay constant for the whole state.
      case (next_state_s)
        LOAD: begin
          s0 <= 1'b0; s1 <= 1'b0; s2 <= 1'b0; addOrSub <= 1'b1; dpDone <= 1'b1;
        end
        STEP_B: begin
          s0 <= 1'b1; s1 <= 1'b0; s2 <= 1'b0; addOrSub <= ops_r[0]; dpDone <= 1'b0;
        end
        STEP_C: begin
          s0 <= 1'b1; s1 <= 1'b1; s2 <= 1'b0; addOrSub <= ops_r[1]; dpDone <= 1'b0;
        end
        STEP_D: begin
          s0 <= 1'b1; s1 <= 1'b0; s2 <= 1'b1; addOrSub <= ops_r[2]; dpDone <= 1'b0;
        end
        default: begin
          // IDLE and DONE: datapath frozen, neutral selects.
          s0 <= 1'b1; s1 <= 1'b0; s2 <= 1'b0; addOrSub <= 1'b1; dpDone <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_sequencer.sv
// ---------------------------------------------------------------------------
// tb_addsub_sequencer: directed self-checking bench for addsub_sequencer.
// A small accumulator model stands in for the datapath: it loads A when s0=0
// and applies the selected operand once, on the first cycle of each step.
// ---------------------------------------------------------------------------
module tb_addsub_sequencer;

  logic              clock;
  logic              reset;
  logic              start;
  logic [1:0]        terms;
  logic [2:0]        ops;
  logic signed [7:0] acc_in;
  logic              s0, s1, s2, addOrSub, dpDone, busy, done;
  logic signed [7:0] result;
  logic              abort;
  logic              aborted;

  int total = 0;
  int bad   = 0;

  // datapath model
  logic signed [7:0] a_v, b_v, c_v, d_v, acc;
  logic [3:0]        prev_sel;
  logic [3:0]        cur_sel;
  logic signed [7:0] opnd;
  logic [4:0]        sel_log [1:64];

  assign cur_sel = {s0, s1, s2, dpDone};
  assign opnd    = s2 ? d_v : (s1 ? c_v : b_v);
  assign acc_in  = acc;

  addsub_sequencer #(.STEP_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .start(start), .terms(terms), .ops(ops),
    .acc_in(acc_in),
`ifdef ADDSUB_SEQ_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .s0(s0), .s1(s1), .s2(s2), .addOrSub(addOrSub), .dpDone(dpDone),
    .busy(busy), .done(done), .result(result)
  );

`ifndef ADDSUB_SEQ_ABORT_EN
  assign aborted = 1'b0;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (cur_sel != prev_sel) begin
      if (!s0) acc <= a_v;
      else if (!dpDone) acc <= addOrSub ? (acc + opnd) : (acc - opnd);
    end
    prev_sel <= cur_sel;
  end

  // Accept a sequence: start is high across one rising edge.
  task automatic start_seq(input logic [1:0] t, input logic [2:0] o,
                           input logic signed [7:0] a, input logic signed [7:0] b,
                           input logic signed [7:0] c, input logic signed [7:0] d,
                           input bit hold);
    a_v = a; b_v = b; c_v = c; d_v = d;
    terms = t; ops = o; start = 1'b1;
    @(posedge clock);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Count negedges until done (bounded); logs selects per cycle.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clock);
      sel_log[n] = {s0, s1, s2, dpDone, addOrSub};
      if (done) begin
        lat = n;
        return;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b1; terms = 2'd0; ops = 3'd0; abort = 1'b0;
    a_v = 8'sd33; b_v = 8'sd0; c_v = 8'sd0; d_v = 8'sd0;
    repeat (3) @(negedge clock);
    total++;
    if ({busy, done, result} !== {1'b0, 1'b0, 8'sd0}) begin
      bad++; $display("FAIL reset_state: busy=%b done=%b result=%0d want 0 0 0", busy, done, result);
    end
    total++;
    if ({s0, s1, s2, addOrSub, dpDone} !== 5'b10011) begin
      bad++; $display("FAIL reset_selects: got %b want 10011", {s0, s1, s2, addOrSub, dpDone});
    end
  endtask

  task automatic test_start_during_reset;
    int lat;
    reset = 1'b1;                 // start still high: first edge with reset=1 accepts
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    total++;
    if ({busy, s0} !== 2'b10) begin
      bad++; $display("FAIL first_accept: busy,s0=%b want 10", {busy, s0});
    end
    wait_done(lat);
    total++;
    if (lat !== 2) begin
      bad++; $display("FAIL first_accept_lat: got %0d want 2", lat);
    end
    total++;
    if (result !== 8'sd33) begin
      bad++; $display("FAIL first_accept_result: got %0d want 33", result);
    end
  endtask

  task automatic test_main;
    int lat;
    logic [4:0] exp_sel [1:9];
    exp_sel[1] = 5'b00011; exp_sel[2] = 5'b00011;   // LOAD
    exp_sel[3] = 5'b10001; exp_sel[4] = 5'b10001;   // STEP_B add
    exp_sel[5] = 5'b11001; exp_sel[6] = 5'b11001;   // STEP_C add
    exp_sel[7] = 5'b10100; exp_sel[8] = 5'b10100;   // STEP_D subtract
    exp_sel[9] = 5'b10011;                          // DONE
    @(negedge clock);
    start_seq(2'd3, 3'b011, 8'sd10, 8'sd5, 8'sd3, -8'sd2, 1'b0);
    terms = 2'd0; ops = 3'b100;   // must be ignored after acceptance
    wait_done(lat);
    total++;
    if (lat !== 9) begin
      bad++; $display("FAIL main_latency: got %0d want 9", lat);
    end
    total++;
    if (result !== 8'sd20) begin
      bad++; $display("FAIL main_result: got %0d want 20", result);
    end
    if (lat == 9) begin
      for (int k = 1; k <= 9; k++) begin
        total++;
        if (sel_log[k] !== exp_sel[k]) begin
          bad++; $display("FAIL main_sel_c%0d: got %b want %b", k, sel_log[k], exp_sel[k]);
        end
      end
    end
    @(negedge clock);
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++; $display("FAIL main_after_done: busy,done=%b want 00", {busy, done});
    end
  endtask

  task automatic test_wrap;
    int lat;
    start_seq(2'd1, 3'b001, 8'sd127, 8'sd1, 8'sd0, 8'sd0, 1'b0);
    wait_done(lat);
    total++;
    if (lat !== 5) begin
      bad++; $display("FAIL wrap_latency: got %0d want 5", lat);
    end
    total++;
    if (result !== -8'sd128) begin
      bad++; $display("FAIL wrap_result: got %0d want -128", result);
    end
  endtask

  task automatic test_terms0;
    int lat;
    @(negedge clock);
    start_seq(2'd0, 3'b111, -8'sd7, 8'sd9, 8'sd9, 8'sd9, 1'b0);
    wait_done(lat);
    total++;
    if (lat !== 3) begin
      bad++; $display("FAIL terms0_latency: got %0d want 3", lat);
    end
    total++;
    if (result !== -8'sd7) begin
      bad++; $display("FAIL terms0_result: got %0d want -7", result);
    end
    total++;
    if ({sel_log[1], sel_log[2], sel_log[3]} !== {5'b00011, 5'b00011, 5'b10011}) begin
      bad++; $display("FAIL terms0_states: got %b %b %b want 00011 00011 10011",
                      sel_log[1], sel_log[2], sel_log[3]);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clock);
    start_seq(2'd1, 3'b000, 8'sd20, 8'sd6, 8'sd0, 8'sd0, 1'b1);
    wait_done(lat);
    total++;
    if (lat !== 5) begin
      bad++; $display("FAIL b2b_first_latency: got %0d want 5", lat);
    end
    @(negedge clock);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL b2b_idle_gap: busy=%b want 0", busy);
    end
    @(negedge clock);
    total++;
    if ({busy, s0} !== 2'b10) begin
      bad++; $display("FAIL b2b_reload: busy,s0=%b want 10", {busy, s0});
    end
    start = 1'b0;
    wait_done(lat);
    total++;
    if (lat !== 4) begin
      bad++; $display("FAIL b2b_second_latency: got %0d want 4", lat);
    end
    total++;
    if (result !== 8'sd14) begin
      bad++; $display("FAIL b2b_result: got %0d want 14", result);
    end
  endtask

`ifdef ADDSUB_SEQ_ABORT_EN
  task automatic test_abort;
    int dones;
    @(negedge clock);
    start_seq(2'd2, 3'b011, 8'sd1, 8'sd2, 8'sd3, 8'sd0, 1'b0);
    repeat (3) @(negedge clock);
    total++;
    if ({s0, s1, s2, dpDone} !== 4'b1000) begin
      bad++; $display("FAIL abort_in_step_b: sel=%b want 1000", {s0, s1, s2, dpDone});
    end
    abort = 1'b1;
    @(negedge clock);
    total++;
    if ({busy, aborted, result} !== {1'b0, 1'b1, 8'sd14}) begin
      bad++; $display("FAIL abort_taken: busy=%b aborted=%b result=%0d want 0 1 14", busy, aborted, result);
    end
    abort = 1'b0;
    dones = 0;
    @(negedge clock);
    total++;
    if (aborted !== 1'b0) begin
      bad++; $display("FAIL abort_pulse: aborted=%b want 0", aborted);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (done) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++; $display("FAIL abort_no_done: got %0d done pulses want 0", dones);
    end
  endtask
`endif

  task automatic test_reset_mid;
    int dones;
    @(negedge clock);
    start_seq(2'd3, 3'b111, 8'sd4, 8'sd4, 8'sd4, 8'sd4, 1'b0);
    repeat (5) @(negedge clock);
    total++;
    if ({s0, s1, s2} !== 3'b110) begin
      bad++; $display("FAIL rstmid_in_step_c: sel=%b want 110", {s0, s1, s2});
    end
    reset = 1'b0;
    @(negedge clock);
    total++;
    if ({busy, done, result} !== {1'b0, 1'b0, 8'sd0}) begin
      bad++; $display("FAIL rstmid_state: busy=%b done=%b result=%0d want 0 0 0", busy, done, result);
    end
    total++;
    if ({s0, s1, s2, addOrSub, dpDone} !== 5'b10011) begin
      bad++; $display("FAIL rstmid_selects: got %b want 10011", {s0, s1, s2, addOrSub, dpDone});
    end
    reset = 1'b1;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (done) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++; $display("FAIL rstmid_no_done: got %0d done pulses want 0", dones);
    end
  endtask

  initial begin
    test_reset();
    test_start_during_reset();
    test_main();
    test_wrap();
    test_terms0();
    test_back_to_back();
`ifdef ADDSUB_SEQ_ABORT_EN
    test_abort();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
